// File: rtl/frame_bmp_pkg.sv
// Shared definitions for the BMP frame streamer: FSM states, header layout
// and small byte-level helpers.
package frame_bmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    EMIT,
    PAD,
    DONE
  } state_t;

  localparam int BMP_HDR_BYTES = 54;

  // Byte offsets of the header fields (file header + BITMAPINFOHEADER)
  localparam logic [5:0] OFS_SIG    = 6'd0;
  localparam logic [5:0] OFS_FSIZE  = 6'd2;
  localparam logic [5:0] OFS_RSVD   = 6'd6;
  localparam logic [5:0] OFS_OFFSET = 6'd10;
  localparam logic [5:0] OFS_DIB    = 6'd14;
  localparam logic [5:0] OFS_WIDTH  = 6'd18;
  localparam logic [5:0] OFS_HEIGHT = 6'd22;
  localparam logic [5:0] OFS_PLANES = 6'd26;
  localparam logic [5:0] OFS_BPP    = 6'd28;
  localparam logic [5:0] OFS_COMP   = 6'd30;
  localparam logic [5:0] OFS_ISIZE  = 6'd34;
  localparam logic [5:0] OFS_XRES   = 6'd38;
  localparam logic [5:0] OFS_YRES   = 6'd42;
  localparam logic [5:0] OFS_CLR    = 6'd46;
  localparam logic [5:0] OFS_IMP    = 6'd50;

  // Zero bytes needed to bring a 24-bit row of w pixels up to a 4-byte multiple
  function automatic int row_pad(input int w);
    return (4 - ((3 * w) % 4)) % 4;
  endfunction

  // Byte idx of a little-endian 32-bit word
  function automatic logic [7:0] le_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Constant 54-byte BMP header lookup; every field is fixed at elaboration.
module bmp_header_rom
  import frame_bmp_pkg::*;
#(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 200,
  parameter int BOTTOM_UP = 0
) (
  input  logic [5:0] idx,
  output logic [7:0] hdr_byte
);

  localparam int          ROWB       = 3 * WIDTH + row_pad(WIDTH);
  localparam logic [31:0] IMG_SIZE   = 32'(ROWB * HEIGHT);
  localparam logic [31:0] FILE_SIZE  = 32'(BMP_HDR_BYTES) + IMG_SIZE;
  localparam logic [31:0] HGT_FIELD  = (BOTTOM_UP != 0) ? 32'(HEIGHT) : 32'(-HEIGHT);
  localparam logic [31:0] RES_PPM    = 32'd2835;

  logic [31:0] field;
  logic [5:0]  base;
  logic [1:0]  sub;

  // Select the field covering idx; zero-valued fields fall through to the default
  always_comb begin
    field = 32'd0;
    base  = 6'd0;
    if (idx < OFS_FSIZE) begin
      field = 32'h0000_4D42;
      base  = OFS_SIG;
    end else if (idx < OFS_RSVD) begin
      field = FILE_SIZE;
      base  = OFS_FSIZE;
    end else if (idx < OFS_OFFSET) begin
      field = 32'd0;
      base  = OFS_RSVD;
    end else if (idx < OFS_DIB) begin
      field = 32'(BMP_HDR_BYTES);
      base  = OFS_OFFSET;
    end else if (idx < OFS_WIDTH) begin
      field = 32'd40;
      base  = OFS_DIB;
    end else if (idx < OFS_HEIGHT) begin
      field = 32'(WIDTH);
      base  = OFS_WIDTH;
    end else if (idx < OFS_PLANES) begin
      field = HGT_FIELD;
      base  = OFS_HEIGHT;
    end else if (idx < OFS_BPP) begin
      field = 32'd1;
      base  = OFS_PLANES;
    end else if (idx < OFS_COMP) begin
      field = 32'd24;
      base  = OFS_BPP;
    end else if (idx < OFS_ISIZE) begin
      field = 32'd0;
      base  = OFS_COMP;
    end else if (idx < OFS_XRES) begin
      field = IMG_SIZE;
      base  = OFS_ISIZE;
    end else if (idx < OFS_YRES) begin
      field = RES_PPM;
      base  = OFS_XRES;
    end else if (idx < OFS_CLR) begin
      field = RES_PPM;
      base  = OFS_YRES;
    end else if (idx < OFS_IMP) begin
      field = 32'd0;
      base  = OFS_CLR;
    end else begin
      field = 32'd0;
      base  = OFS_IMP;
    end
    sub      = 2'(idx - base);
    hdr_byte = le_byte(field, sub);
  end

endmodule

// File: rtl/frame_bmp_streamer.sv
// Scans a renderer over a WIDTH x HEIGHT window and streams the result as a
// 24-bit BMP byte stream over a valid/ready interface.
module frame_bmp_streamer
  import frame_bmp_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 200,
  parameter int COLOR_BITS = 4,
  parameter int PIPE_LAT   = 1,
  parameter int BOTTOM_UP  = 0,
  parameter int HEADER_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [9:0]            drawX,
  output logic [9:0]            drawY,
  input  logic [COLOR_BITS-1:0] red,
  input  logic [COLOR_BITS-1:0] green,
  input  logic [COLOR_BITS-1:0] blue,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int         PADB    = row_pad(WIDTH);
  localparam logic [9:0] X_LAST  = 10'(WIDTH - 1);
  localparam logic [9:0] Y_FIRST = (BOTTOM_UP != 0) ? 10'(HEIGHT - 1) : 10'd0;
  localparam logic [9:0] Y_END   = (BOTTOM_UP != 0) ? 10'd0 : 10'(HEIGHT - 1);

  state_t      state, state_nxt;
  logic [5:0]  hdr_idx;
  logic [9:0]  x, y;
  logic [3:0]  lat_cnt;
  logic [1:0]  chan;
  logic [1:0]  pad_cnt;
  logic [23:0] pix_hold;
  logic [7:0]  hdr_byte;
  logic [7:0]  emit_byte;
  logic        emitting, xfer;
  logic        x_last, y_last, pad_last, lat_done;

  // MSB-aligned, zero-filled expansion of one renderer channel to 8 bits
  function automatic logic [7:0] expand_chan(input logic [COLOR_BITS-1:0] c);
    logic [7:0] r;
    r = 8'd0;
    r[7 -: COLOR_BITS] = c;
    return r;
  endfunction

  bmp_header_rom #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .BOTTOM_UP (BOTTOM_UP)
  ) u_hdr (
    .idx      (hdr_idx),
    .hdr_byte (hdr_byte)
  );

  assign emitting = (state == HDR) || (state == EMIT) || (state == PAD);
  assign xfer     = emitting && m_ready;
  assign x_last   = (x == X_LAST);
  assign y_last   = (y == Y_END);
  assign pad_last = (pad_cnt == 2'(PADB - 1));
  assign lat_done = (lat_cnt == 4'(PIPE_LAT));
  assign drawX    = x;
  assign drawY    = y;

  // Byte order within a pixel is B, G, R
  always_comb begin
    case (chan)
      2'd0:    emit_byte = pix_hold[7:0];
      2'd1:    emit_byte = pix_hold[15:8];
      default: emit_byte = pix_hold[23:16];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and stream outputs; indices only move on a handshake,
  // so m_data/m_last stay stable while the sink stalls
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    m_valid   = emitting;
    m_data    = 8'd0;
    m_last    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (HEADER_EN != 0) ? HDR : FETCH;
      end
      HDR: begin
        m_data = hdr_byte;
        if (xfer && (hdr_idx == 6'(BMP_HDR_BYTES - 1))) state_nxt = FETCH;
      end
      FETCH: begin
        if (lat_done) state_nxt = EMIT;
      end
      EMIT: begin
        m_data = emit_byte;
        m_last = (chan == 2'd2) && x_last && (PADB == 0) && y_last;
        if (xfer && (chan == 2'd2)) begin
          if (!x_last)      state_nxt = FETCH;
          else if (PADB > 0) state_nxt = PAD;
          else if (y_last)  state_nxt = DONE;
          else              state_nxt = FETCH;
        end
      end
      PAD: begin
        m_data = 8'd0;
        m_last = pad_last && y_last;
        if (xfer && pad_last) state_nxt = y_last ? DONE : FETCH;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Scan counters: header index, pixel position, settle counter, byte lanes
  always_ff @(posedge clk) begin
    if (!reset) begin
      hdr_idx <= 6'd0;
      x       <= 10'd0;
      y       <= 10'd0;
      lat_cnt <= 4'd0;
      chan    <= 2'd0;
      pad_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hdr_idx <= 6'd0;
            x       <= 10'd0;
            y       <= Y_FIRST;
            lat_cnt <= 4'd0;
            chan    <= 2'd0;
            pad_cnt <= 2'd0;
          end
        end
        HDR: begin
          if (xfer) hdr_idx <= hdr_idx + 6'd1;
        end
        FETCH: begin
          if (lat_done) begin
            lat_cnt <= 4'd0;
            chan    <= 2'd0;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (chan == 2'd2) begin
              chan <= 2'd0;
              if (!x_last) begin
                x <= x + 10'd1;
              end else if (PADB > 0) begin
                pad_cnt <= 2'd0;
              end else begin
                x <= 10'd0;
                if (!y_last) y <= (BOTTOM_UP != 0) ? y - 10'd1 : y + 10'd1;
              end
            end else begin
              chan <= chan + 2'd1;
            end
          end
        end
        PAD: begin
          if (xfer) begin
            if (pad_last) begin
              pad_cnt <= 2'd0;
              x       <= 10'd0;
              if (!y_last) y <= (BOTTOM_UP != 0) ? y - 10'd1 : y + 10'd1;
            end else begin
              pad_cnt <= pad_cnt + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel capture on the last settle cycle of FETCH, packed as {R,G,B}
  always_ff @(posedge clk) begin
    if ((state == FETCH) && lat_done)
      pix_hold <= {expand_chan(red), expand_chan(green), expand_chan(blue)};
  end

endmodule

// File: tb/tb_frame_bmp_streamer.sv
// Scoreboard bench for frame_bmp_streamer: three configurations share a clock.
//  A: 3x2, header, top-down, combinational renderer
//  B: 4x2, no header, bottom-up, PIPE_LAT=3 with a registered renderer, random ready
//  C: 100x200 defaults, header bytes only
module tb_frame_bmp_streamer;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // ---------------- DUT A ----------------
  logic       reset_a, start_a, busy_a, done_a, m_valid_a, m_ready_a, m_last_a;
  logic [9:0] dx_a, dy_a;
  logic [3:0] red_a, green_a, blue_a;
  logic [7:0] m_data_a;
  assign red_a   = dx_a[3:0];
  assign green_a = dy_a[3:0];
  assign blue_a  = 4'hF;

  frame_bmp_streamer #(.WIDTH(3), .HEIGHT(2), .COLOR_BITS(4), .PIPE_LAT(1),
                       .BOTTOM_UP(0), .HEADER_EN(1)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
    .drawX(dx_a), .drawY(dy_a), .red(red_a), .green(green_a), .blue(blue_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a));

  // ---------------- DUT B ----------------
  logic       reset_b, start_b, busy_b, done_b, m_valid_b, m_last_b;
  logic       m_ready_b = 1'b1;
  logic       rand_b = 1'b0;
  logic [9:0] dx_b, dy_b;
  logic [3:0] red_b, green_b, blue_b;
  logic [7:0] m_data_b;
  logic [3:0] rbx_p0, rbx_p1, rbx_p2, rby_p0, rby_p1, rby_p2;

  always @(posedge clk) begin
    rbx_p0 <= dx_b[3:0];
    rby_p0 <= dy_b[3:0];
    rbx_p1 <= rbx_p0;
    rby_p1 <= rby_p0;
    rbx_p2 <= rbx_p1;
    rby_p2 <= rby_p1;
  end
  assign red_b   = rbx_p2;
  assign green_b = rby_p2;
  assign blue_b  = rbx_p2 + rby_p2;

  always @(posedge clk) begin
    #1;
    m_ready_b <= rand_b ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  frame_bmp_streamer #(.WIDTH(4), .HEIGHT(2), .COLOR_BITS(4), .PIPE_LAT(3),
                       .BOTTOM_UP(1), .HEADER_EN(0)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
    .drawX(dx_b), .drawY(dy_b), .red(red_b), .green(green_b), .blue(blue_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b));

  // ---------------- DUT C ----------------
  logic       reset_c, start_c, busy_c, done_c, m_valid_c, m_ready_c, m_last_c;
  logic [9:0] dx_c, dy_c;
  logic [3:0] red_c, green_c, blue_c;
  logic [7:0] m_data_c;
  assign red_c   = dx_c[3:0];
  assign green_c = dy_c[3:0];
  assign blue_c  = 4'h0;

  frame_bmp_streamer dut_c (
    .clk(clk), .reset(reset_c), .start(start_c), .busy(busy_c), .done(done_c),
    .drawX(dx_c), .drawY(dy_c), .red(red_c), .green(green_c), .blue(blue_c),
    .m_data(m_data_c), .m_valid(m_valid_c), .m_ready(m_ready_c), .m_last(m_last_c));

  // ---------------- checking helpers ----------------
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_extra(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got byte 0x%0h, expected no byte", name, act);
  endfunction

  // Hand-computed header for a 3x2 top-down image (ROWB=12, image 24, file 78)
  logic [7:0] hdr_a [54] = '{
    8'h42, 8'h4D, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00,
    8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h18, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0B,
    8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00};

  // First 30 header bytes of the default 100x200 image (file 60054, height -200)
  logic [7:0] hdr_c [30] = '{
    8'h42, 8'h4D, 8'h96, 8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00,
    8'h00, 8'h00, 8'h38, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h18, 8'h00};

  // A: B=0xF0, G=y<<4, R=x<<4, three zero pad bytes per row, last = byte 77
  function automatic void push_frame_a();
    int n;
    n = 0;
    for (int i = 0; i < 54; i++) begin q_a.push_back('{hdr_a[i], 1'b0}); n++; end
    for (int yy = 0; yy < 2; yy++) begin
      for (int xx = 0; xx < 3; xx++) begin
        q_a.push_back('{8'hF0, 1'b0});
        q_a.push_back('{8'(yy << 4), 1'b0});
        q_a.push_back('{8'(xx << 4), 1'b0});
        n += 3;
      end
      for (int p = 0; p < 3; p++) begin
        q_a.push_back('{8'h00, (n == 77)});
        n++;
      end
    end
  endfunction

  // B: rows y=1 then y=0; B=(x+y)<<4, G=y<<4, R=x<<4, last = byte 23
  function automatic void push_frame_b();
    int n;
    n = 0;
    for (int yi = 0; yi < 2; yi++) begin
      for (int xx = 0; xx < 4; xx++) begin
        q_b.push_back('{8'(((xx + 1 - yi)) << 4), 1'b0});
        q_b.push_back('{8'((1 - yi) << 4), 1'b0});
        q_b.push_back('{8'(xx << 4), (n + 2 == 23)});
        n += 3;
      end
    end
  endfunction

  function automatic bit pending(input int sel);
    case (sel)
      0:       return (q_a.size() != 0) || busy_a;
      1:       return (q_b.size() != 0) || busy_b;
      default: return (q_c.size() != 0);
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic wait_q(input int sel, input int limit, input string name);
    int n;
    n = 0;
    while (pending(sel) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_bytes_left"}, qsize(sel), 0);
    if (sel != 2) begin
      chk({name, "_busy_end"}, (sel == 0) ? busy_a : busy_b, 0);
      repeat (3) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- monitor ----------------
  logic       done_pend_a = 1'b0, done_pend_b = 1'b0;
  int         done_cnt_a = 0, done_cnt_b = 0;
  logic       stall_b = 1'b0, pl_b;
  logic [7:0] pd_b;
  logic [9:0] px_b, py_b;

  always @(negedge clk) begin
    if (reset_a) begin
      if (done_pend_a)  chk("a_done_pulse", done_a, 1);
      else if (done_a)  chk("a_done_spurious", done_a, 0);
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      done_pend_a <= 1'b0;
      if (m_valid_a && m_ready_a) begin
        if (q_a.size() == 0) fail_extra("a_extra_byte", m_data_a);
        else begin
          chk("a_data", m_data_a, q_a[0].d);
          chk("a_last", m_last_a, q_a[0].l);
          void'(q_a.pop_front());
        end
        done_pend_a <= m_last_a;
      end
    end else begin
      done_pend_a <= 1'b0;
    end

    if (reset_b) begin
      if (done_pend_b)  chk("b_done_pulse", done_b, 1);
      else if (done_b)  chk("b_done_spurious", done_b, 0);
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      done_pend_b <= 1'b0;
      if (stall_b) begin
        chk("b_valid_hold", m_valid_b, 1);
        chk("b_data_hold", m_data_b, pd_b);
        chk("b_last_hold", m_last_b, pl_b);
        chk("b_drawx_hold", dx_b, px_b);
        chk("b_drawy_hold", dy_b, py_b);
      end
      stall_b <= m_valid_b && !m_ready_b;
      pd_b    <= m_data_b;
      pl_b    <= m_last_b;
      px_b    <= dx_b;
      py_b    <= dy_b;
      if (m_valid_b && m_ready_b) begin
        if (q_b.size() == 0) fail_extra("b_extra_byte", m_data_b);
        else begin
          chk("b_data", m_data_b, q_b[0].d);
          chk("b_last", m_last_b, q_b[0].l);
          void'(q_b.pop_front());
        end
        done_pend_b <= m_last_b;
      end
    end else begin
      stall_b     <= 1'b0;
      done_pend_b <= 1'b0;
    end

    if (reset_c && m_valid_c && m_ready_c) begin
      if (q_c.size() == 0) fail_extra("c_extra_byte", m_data_c);
      else begin
        chk("c_hdr_data", m_data_c, q_c[0].d);
        chk("c_hdr_last", m_last_c, q_c[0].l);
        chk("c_done_low", done_c, 0);
        void'(q_c.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    m_ready_a = 1'b1; m_ready_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  busy_a,    0);
    chk("rst_done",  done_a,    0);
    chk("rst_valid", m_valid_a, 0);
    chk("rst_last",  m_last_a,  0);
    chk("rst_data",  m_data_a,  0);
    chk("rst_drawx", dx_a,      0);
    chk("rst_drawy", dy_a,      0);
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    @(posedge clk); #1;

    // C: default geometry, header bytes 0..29, then hold in reset
    for (int i = 0; i < 30; i++) q_c.push_back('{hdr_c[i], 1'b0});
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    chk("c_busy_after_start", busy_c, 1);
    wait_q(2, 200, "c_header");
    reset_c = 1'b0;

    // A frame 1: full frame, sink always ready
    push_frame_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1);
    wait_q(0, 1000, "a_frame1");
    chk("a_frame1_done_cnt", done_cnt_a, 1);

    // A frame 2: reset while emitting pixel (1,1)
    push_frame_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (!(m_valid_a && dx_a == 10'd1 && dy_a == 10'd1) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_reach_pix11_timeout", int'(n < 1000), 1);
    reset_a = 1'b0;
    @(posedge clk); #1;
    chk("a_midrst_valid", m_valid_a, 0);
    chk("a_midrst_busy",  busy_a,    0);
    q_a.delete();
    reset_a = 1'b1;
    @(posedge clk); #1;

    // A frame 3: complete frame after reset; starts while busy and in DONE ignored
    push_frame_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_busy_after_ignored_start", busy_a, 1);
    n = 0;
    while (!done_a && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_done_seen_timeout", int'(n < 1000), 1);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("a_idle_after_done_start", busy_a, 0);
    chk("a_frame3_bytes_left", q_a.size(), 0);
    chk("a_total_done_cnt", done_cnt_a, 2);

    // B frame 1: ready held high
    push_frame_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_q(1, 1000, "b_frame1");
    chk("b_frame1_done_cnt", done_cnt_b, 1);

    // B frame 2: ready at ~30% duty, identical stream expected
    rand_b = 1'b1;
    push_frame_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_q(1, 3000, "b_frame2");
    chk("b_frame2_done_cnt", done_cnt_b, 2);
    rand_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
